serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first, one bit per clock,
// through a three-state IDLE/RUN/DONE controller with registered outputs.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic             br_q, bout_q, busy_q, done_q;
  logic [CW-1:0]    cnt_q;

  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  // Full-subtractor cell on the current LSB pair and the next result shift value
  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d    = {d_bit, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Controller and datapath; the counter parks at WIDTH-1 on the last bit so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          if (last_bit) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=3.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start3 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy8, done8, bout8, busy3, done3, bout3;
  logic [7:0] diff8;
  logic [2:0] diff3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] prev8 = '0, prev3 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full operation on the selected instance (w3=1 -> WIDTH=3 DUT).
  // Operands are scrambled right after acceptance; diff must hold its old value until done.
  task automatic run_op(input bit w3, input logic [7:0] ta, input logic [7:0] tb_v,
                        input bit full_checks,
                        output logic [31:0] rd, output logic rb);
    int unsigned lat, bc, w;
    logic [31:0] held;
    w = w3 ? 3 : 8;
    @(negedge clk);
    if (w3) begin start3 = 1'b1; a3 = ta[2:0]; b3 = tb_v[2:0]; end
    else    begin start8 = 1'b1; a8 = ta;      b8 = tb_v;      end
    @(negedge clk);
    start3 = 1'b0; start8 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1; bc = 0; held = '0;
    forever begin
      if (w3 ? busy3 : busy8) bc++;
      if (w3 ? done3 : done8) break;
      held = w3 ? 32'(diff3) : 32'(diff8);
      if (lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    rd = w3 ? 32'(diff3) : 32'(diff8);
    rb = w3 ? bout3 : bout8;
    if (full_checks || lat >= 40) begin
      chk("done_latency", lat, w + 1);
      if (full_checks) begin
        chk("busy_cycles", bc, w + 1);
        chk("diff_held_during_run", held, w3 ? prev3 : prev8);
        @(negedge clk);
        chk("idle_after_done", {30'd0, (w3 ? busy3 : busy8), (w3 ? done3 : done8)}, 32'd0);
        chk("diff_held_in_idle", w3 ? 32'(diff3) : 32'(diff8), rd);
      end
    end
  endtask

  logic [31:0] rd;
  logic        rb;
  logic [7:0]  sa[64], sb[64];
  int          dones[$];
  int unsigned done_seen;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 8'h5A, 8'hE2, 1'b1};
    vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};

    // Reset state
    #12;
    chk("reset_outputs8", {22'd0, busy8, done8, diff8}, 32'd0);
    chk("reset_bout8", {31'd0, bout8}, 32'd0);
    chk("reset_outputs3", {26'd0, busy3, done3, bout3, diff3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, 1'b1, rd, rb);
      chk($sformatf("vec%0d_diff", i), rd, 32'(vecs[i].d));
      chk($sformatf("vec%0d_bout", i), {31'd0, rb}, {31'd0, vecs[i].bo});
      prev8 = 32'(vecs[i].d);
    end

    // A few directed WIDTH=3 operations including wrap and equal operands
    run_op(1'b1, 8'd0, 8'd7, 1'b1, rd, rb);
    chk("w3_0m7_diff", rd, 32'd1);
    chk("w3_0m7_bout", {31'd0, rb}, 32'd1);
    prev3 = 32'd1;
    run_op(1'b1, 8'd7, 8'd2, 1'b1, rd, rb);
    chk("w3_7m2_diff", rd, 32'd5);
    chk("w3_7m2_bout", {31'd0, rb}, 32'd0);
    prev3 = 32'd5;

    // Start held high with operands changing every cycle
    for (int k = 0; k < 64; k++) begin
      sa[k] = 8'($urandom);
      sb[k] = 8'($urandom);
    end
    @(negedge clk);
    for (int k = 0; k < 45; k++) begin
      if (done8) begin
        dones.push_back(k);
        if (k >= 9) begin
          chk("held_start_diff", 32'(diff8), 32'(8'(sa[k-9] - sb[k-9])));
          chk("held_start_bout", {31'd0, bout8}, {31'd0, sa[k-9] < sb[k-9]});
        end
      end
      start8 = 1'b1; a8 = sa[k]; b8 = sb[k];
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("held_start_done_count", dones.size(), 4);
    if (dones.size() == 4) begin
      chk("held_start_first_done", dones[0], 9);
      for (int i = 1; i < 4; i++) chk("held_start_spacing", dones[i] - dones[i-1], 10);
    end
    repeat (12) @(negedge clk);

    // Mid-operation reset
    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, rd, rb);
    chk("pre_reset_diff", rd, 32'h1E);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {22'd0, busy8, done8, diff8}, 32'd0);
    chk("abort_bout", {31'd0, bout8}, 32'd0);
    done_seen = 0;
    repeat (2) begin @(negedge clk); if (done8) done_seen++; end
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); if (done8 || busy8) done_seen++; end
    chk("no_done_after_abort", done_seen, 0);
    prev8 = '0;
    run_op(1'b0, 8'h10, 8'h20, 1'b1, rd, rb);
    chk("post_reset_diff", rd, 32'hF0);
    chk("post_reset_bout", {31'd0, rb}, 32'd1);
    prev8 = 32'hF0;

    // Random operands against (a-b) mod 2^W and a<b
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rbv;
      ra = 8'($urandom); rbv = 8'($urandom);
      run_op(1'b0, ra, rbv, 1'b0, rd, rb);
      chk("rand8_diff", rd, 32'(8'(ra - rbv)));
      chk("rand8_bout", {31'd0, rb}, {31'd0, ra < rbv});
    end
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] ra, rbv;
      ra = 3'($urandom); rbv = 3'($urandom);
      run_op(1'b1, 8'(ra), 8'(rbv), 1'b0, rd, rb);
      chk("rand3_diff", rd, 32'(3'(ra - rbv)));
      chk("rand3_bout", {31'd0, rb}, {31'd0, ra < rbv});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
